aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Sequencer that sits directly upstream of aes_rounddata and owns the AES state register between rounds. It accepts a 128-bit block on a start handshake, drives `round`, `width_sel` and `data_in` to the byte-serial round datapath, and captures the datapath result at each round boundary. It waits on the key schedule's `key_valid` before every round and returns the ciphertext with a one-cycle `done` pulse.

Parameters:
- SUBROUNDS, 16, byte sub-rounds per AES round (`width_sel` range 0..SUBROUNDS-1); only 16 is supported.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to encrypt `block_in`; sampled only in IDLE.
- mode  in  2  key size: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 is treated as 10. Latched on start accept.
- block_in  in  128  plaintext; latched on start accept.
- key_valid  in  1  key schedule has `round_key` for the current `round` stable.
- rd_data_out  in  128  `data_out` from aes_rounddata.
- round  out  4  round index to the datapath and key schedule.
- width_sel  out  4  byte sub-round index to the datapath.
- rd_mode  out  2  latched mode, driven to the datapath `mode` input.
- state_out  out  128  AES state register, driven to the datapath `data_in` input.
- busy  out  1  encryption in progress.
- done  out  1  one-cycle pulse; `block_out` is valid.
- block_out  out  128  ciphertext; holds until the next completion.

Behaviour:
- Reset values (reset=1 at an edge, from any state, including mid-encryption):
  - FSM to IDLE.
  - `round`, `width_sel`, `rd_mode`, `state_out`, `block_out` all 0.
  - `busy` = 0, `done` = 0.
  - Latched Nr = 10.
  - Any in-flight block is discarded and no `done` is emitted.
- Nr derivation: Nr = 10 (mode 00), 12 (01), 14 (10 or 11). It is latched at accept, so `mode` changes while busy are ignored.
- FSM states: IDLE, R0, ROUND.
- IDLE:
  - `busy` = 0, `round` = 0, `width_sel` = 0.
  - If start=1 at an edge: `state_out` <= `block_in`, latch mode and Nr, go to R0, `busy` = 1 from the next cycle.
- R0 (initial AddRoundKey, combinational in the datapath):
  - `round` = 0, `width_sel` = 0.
  - At an edge with key_valid=1: `state_out` <= `rd_data_out`, `round` <= 1, `width_sel` <= 0, go to ROUND.
  - With key_valid=0: hold. No cycle is lost when key_valid is already 1.
- ROUND:
  - `width_sel` increments by 1 each edge, 0 to 15.
  - Boundary stall: when `width_sel` = 0 and key_valid = 0, hold `width_sel` at 0 with `round` and `state_out` unchanged. This stall is only legal at `width_sel` = 0; `key_valid` is ignored for `width_sel` 1..15.
  - Capture at the edge ending the `width_sel` = 15 cycle: `state_out` <= `rd_data_out`, `width_sel` <= 0.
  - If `round` < Nr: `round` <= `round` + 1, stay in ROUND.
  - If `round` = Nr: `block_out` <= `rd_data_out`, `done` <= 1 for exactly one cycle, `busy` <= 0, go to IDLE with `round` = 0.
- Latency with `key_valid` held at 1: start accepted at edge E0, `done` is high in the cycle after edge E0 + 1 + 16·Nr.
  - AES-128: E0 + 161
  - AES-192: E0 + 193
  - AES-256: E0 + 225
  - Each cycle of `key_valid` = 0 at a boundary adds one cycle.
- Start handling:
  - start while `busy` is ignored; it is not queued.
  - start in the same cycle `done` is high is accepted, because the FSM is already in IDLE.
  - Back-to-back blocks therefore have zero idle cycles.
- Counter widths:
  - `width_sel` wraps 15 to 0 only through the capture path.
  - `round` never exceeds 14.
  - No arithmetic overflow is possible.

Test Plan:
- AES-128, FIPS-197 C.1: pt 00112233445566778899aabbccddeeff, key 000102…0f, `key_valid` tied 1 → `done` at E0+161, `block_out` = 69c4e0d86a7b0430d8cdb78070b4c55a, `busy` high for exactly 161 cycles.
- AES-192, C.2: key 000102…17 → `block_out` = dda97ca4864cdfe06eaf70a0ec0d7191 at E0+193. AES-256, C.3: key 000102…1f → `block_out` = 8ea2b7ca516745bfeafc49904b496089 at E0+225. Repeat C.3 with mode=11 and expect an identical result.
- Key stall: C.1 with `key_valid` = 0 for 3 cycles at the round-0 entry and 5 cycles at the round-4 boundary → same ciphertext, `done` at E0+169. `width_sel` holds at 0 and `round` holds during the stalls.
- Handshake: start pulsed at cycles 10, 50 and 100 during a C.1 run → only one `done`. Then start asserted in the `done` cycle with block C.3 under AES-256 → accepted immediately, second correct `done` 225 cycles later. `block_out` holds the first result until then.
- Reset mid-operation: assert reset at `round` = 5, `width_sel` = 7 → next cycle all outputs are 0 and the FSM is in IDLE, with no `done`. A fresh C.1 start then completes correctly at E0+161.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the byte-serial AES datapath: owns the state register between rounds,
// steps round/width_sel, and captures the datapath result at every round boundary.
module aes_round_ctrl #(
    parameter int SUBROUNDS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [127:0] block_in,
    input  logic         key_valid,
    input  logic [127:0] rd_data_out,
    output logic [3:0]   round,
    output logic [3:0]   width_sel,
    output logic [1:0]   rd_mode,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         done,
    output logic [127:0] block_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        R0    = 2'd1,
        ROUND = 2'd2
    } state_t;

    localparam logic [3:0] LAST_SUB = 4'(SUBROUNDS - 1);

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   width_sel_q, width_sel_d;
    logic [1:0]   mode_q, mode_d;
    logic [3:0]   nr_q, nr_d;
    logic [127:0] data_q, data_d;
    logic [127:0] block_out_q, block_out_d;
    logic         done_q, done_d;

    function automatic logic [3:0] nr_for(input logic [1:0] m);
        case (m)
            2'b00:   nr_for = 4'd10;
            2'b01:   nr_for = 4'd12;
            default: nr_for = 4'd14;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            round_q     <= 4'd0;
            width_sel_q <= 4'd0;
            mode_q      <= 2'b00;
            nr_q        <= 4'd10;
            data_q      <= 128'd0;
            block_out_q <= 128'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            width_sel_q <= width_sel_d;
            mode_q      <= mode_d;
            nr_q        <= nr_d;
            data_q      <= data_d;
            block_out_q <= block_out_d;
            done_q      <= done_d;
        end
    end

    // start is only looked at in IDLE; key_valid gates R0 and the width_sel==0 slot of every
    // round and is ignored for the rest of the sub-rounds.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        width_sel_d = width_sel_q;
        mode_d      = mode_q;
        nr_d        = nr_q;
        data_d      = data_q;
        block_out_d = block_out_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                round_d     = 4'd0;
                width_sel_d = 4'd0;
                if (start) begin
                    data_d  = block_in;
                    mode_d  = (mode == 2'b11) ? 2'b10 : mode;
                    nr_d    = nr_for(mode);
                    state_d = R0;
                end
            end
            R0: begin
                if (key_valid) begin
                    data_d      = rd_data_out;
                    round_d     = 4'd1;
                    width_sel_d = 4'd0;
                    state_d     = ROUND;
                end
            end
            ROUND: begin
                if (width_sel_q == 4'd0 && !key_valid) begin
                    width_sel_d = 4'd0;
                end else if (width_sel_q == LAST_SUB) begin
                    data_d      = rd_data_out;
                    width_sel_d = 4'd0;
                    if (round_q == nr_q) begin
                        block_out_d = rd_data_out;
                        done_d      = 1'b1;
                        round_d     = 4'd0;
                        state_d     = IDLE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    width_sel_d = width_sel_q + 4'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                round_d     = 4'd0;
                width_sel_d = 4'd0;
            end
        endcase
    end

    assign round     = round_q;
    assign width_sel = width_sel_q;
    assign rd_mode   = mode_q;
    assign state_out = data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign block_out = block_out_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES round datapath and key schedule
// standing in for aes_rounddata, checked against the FIPS-197 appendix C vectors.
module tb_aes_round_ctrl;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] JUNK = 128'hdeadbeef0badf00dcafebabe55aa33cc;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   mode;
    logic [127:0] block_in;
    logic         key_valid;
    logic [127:0] rd_data_out;
    logic [3:0]   round;
    logic [3:0]   width_sel;
    logic [1:0]   rd_mode;
    logic [127:0] state_out;
    logic         busy;
    logic         done;
    logic [127:0] block_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] rk_tab [0:2][0:14];
    logic [31:0]  w      [0:59];

    aes_round_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .block_in    (block_in),
        .key_valid   (key_valid),
        .rd_data_out (rd_data_out),
        .round       (round),
        .width_sel   (width_sel),
        .rd_mode     (rd_mode),
        .state_out   (state_out),
        .busy        (busy),
        .done        (done),
        .block_out   (block_out)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] res, aa, bb;
        res = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) res = res ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        gmul = res;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        rotl8 = (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] x);
        subword = {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    function automatic int sel_of(input logic [1:0] m);
        sel_of = (m == 2'b00) ? 0 : (m == 2'b01) ? 1 : 2;
    endfunction

    // One full AES round on a FIPS-ordered block (byte 0 in the top bits, column-major state).
    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                               input bit last);
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = sbox_t[st[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*c];
            end else begin
                s[4*c]   = xtime(t[4*c]) ^ xtime(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                s[4*c+1] = t[4*c] ^ xtime(t[4*c+1]) ^ xtime(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xtime(t[4*c+2]) ^ xtime(t[4*c+3]) ^ t[4*c+3];
                s[4*c+3] = xtime(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xtime(t[4*c+3]);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        aes_round = o ^ k;
    endfunction

    // datapath stand-in: result for the current round, ready well before the capture edge
    always @(negedge clk) begin
        if (round == 4'd0)
            rd_data_out <= state_out ^ rk_tab[sel_of(rd_mode)][0];
        else
            rd_data_out <= aes_round(state_out, rk_tab[sel_of(rd_mode)][round],
                                     int'(round) == 10 + 2 * sel_of(rd_mode));
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [127:0] pt);
        block_in = pt;
        mode     = m;
        start    = 1'b1;
        tick();
        start = 1'b0;
        e0    = cyc;
    endtask

    task automatic wait_done(input int exp_lat, input logic [127:0] exp_ct, input string tag,
                             output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        busy_cnt = int'(busy);
        for (int n = 0; n < 400 && !seen; n++) begin
            tick();
            if (done) seen = 1'b1;
            else busy_cnt += int'(busy);
        end
        chk({tag, "_done_seen"}, 128'(seen), 128'(1'b1));
        if (seen) begin
            chk({tag, "_latency"}, 128'(cyc - e0), 128'(exp_lat));
            chk({tag, "_block_out"}, block_out, exp_ct);
            chk({tag, "_busy_at_done"}, 128'(busy), 128'(1'b0));
            tick();
            chk({tag, "_done_one_cycle"}, 128'(done), 128'(1'b0));
        end
    endtask

    initial begin
        int bc;
        int ndone;
        bit hit;
        logic [127:0] held;
        logic [255:0] key256;

        reset = 1'b1; start = 1'b0; mode = 2'b00; block_in = '0; key_valid = 1'b1;

        // reference S-box and round keys for the three FIPS-197 appendix C keys
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b, p;
            b = 8'(x);
            p = 8'h01;
            for (int e = 0; e < 254; e++) p = gmul(p, b);
            sbox_t[x] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
        end
        key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        for (int sel = 0; sel < 3; sel++) begin
            int nk, nr;
            logic [7:0] rcon;
            logic [31:0] temp;
            nk = 4 + 2 * sel;
            nr = 10 + 2 * sel;
            rcon = 8'h01;
            for (int i = 0; i < nk; i++) w[i] = key256[255-32*i -: 32];
            for (int i = nk; i < 4 * (nr + 1); i++) begin
                temp = w[i-1];
                if (i % nk == 0) begin
                    temp = subword({temp[23:0], temp[31:24]}) ^ {rcon, 24'h000000};
                    rcon = xtime(rcon);
                end else if (nk == 8 && i % nk == 4) begin
                    temp = subword(temp);
                end
                w[i] = w[i-nk] ^ temp;
            end
            for (int r = 0; r <= nr; r++) rk_tab[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end

        // reset values
        tick(); tick();
        reset = 1'b0;
        chk("rst_round", 128'(round), 128'(4'd0));
        chk("rst_width_sel", 128'(width_sel), 128'(4'd0));
        chk("rst_rd_mode", 128'(rd_mode), 128'(2'b00));
        chk("rst_state_out", state_out, 128'd0);
        chk("rst_block_out", block_out, 128'd0);
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));

        // AES-128, C.1
        do_start(2'b00, PT);
        chk("c1_busy_after_accept", 128'(busy), 128'(1'b1));
        chk("c1_state_loaded", state_out, PT);
        chk("c1_r0_round", 128'(round), 128'(4'd0));
        wait_done(161, CT1, "c1", bc);
        chk("c1_busy_cycles", 128'(bc), 128'(161));

        // AES-192, C.2, mode changed while busy must not matter
        do_start(2'b01, PT);
        mode = 2'b00;
        chk("c2_rd_mode", 128'(rd_mode), 128'(2'b01));
        wait_done(193, CT2, "c2", bc);

        // AES-256, C.3, then again with mode 11
        do_start(2'b10, PT);
        chk("c3_rd_mode", 128'(rd_mode), 128'(2'b10));
        wait_done(225, CT3, "c3", bc);
        do_start(2'b11, PT);
        wait_done(225, CT3, "c3_mode11", bc);

        // key stall: 3 cycles in R0, 5 cycles at the round-4 boundary
        do_start(2'b00, PT);
        key_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_r0_round", 128'(round), 128'(4'd0));
            chk("stall_r0_width_sel", 128'(width_sel), 128'(4'd0));
            chk("stall_r0_state", state_out, PT);
        end
        key_valid = 1'b1;
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            tick();
            if (round == 4'd4) hit = 1'b1;
        end
        chk("stall_reach_round4", 128'(hit), 128'(1'b1));
        chk("stall_r4_entry_width_sel", 128'(width_sel), 128'(4'd0));
        held = state_out;
        key_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_r4_round", 128'(round), 128'(4'd4));
            chk("stall_r4_width_sel", 128'(width_sel), 128'(4'd0));
            chk("stall_r4_state", state_out, held);
        end
        key_valid = 1'b1;
        wait_done(169, CT1, "stall", bc);

        // start pulses while busy are ignored; start in the done cycle is accepted
        do_start(2'b00, PT);
        block_in = JUNK;
        mode     = 2'b10;
        ndone    = 0;
        for (int k = 1; k <= 160; k++) begin
            start = (k == 10 || k == 50 || k == 100);
            tick();
            if (done) ndone++;
        end
        start = 1'b0;
        tick();
        chk("hs_no_early_done", 128'(ndone), 128'(0));
        chk("hs_done_at_161", 128'(done), 128'(1'b1));
        chk("hs_latency", 128'(cyc - e0), 128'(161));
        chk("hs_block_out", block_out, CT1);
        do_start(2'b10, PT);
        chk("hs_b2b_busy", 128'(busy), 128'(1'b1));
        chk("hs_b2b_done_low", 128'(done), 128'(1'b0));
        chk("hs_b2b_state", state_out, PT);
        for (int k = 0; k < 100; k++) tick();
        chk("hs_block_out_held", block_out, CT1);
        wait_done(225, CT3, "hs_second", bc);

        // reset in the middle of an AES-256 run
        do_start(2'b10, PT);
        hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            tick();
            if (round == 4'd5 && width_sel == 4'd7) hit = 1'b1;
        end
        chk("mid_reach_r5_w7", 128'(hit), 128'(1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_round", 128'(round), 128'(4'd0));
        chk("mid_rst_width_sel", 128'(width_sel), 128'(4'd0));
        chk("mid_rst_rd_mode", 128'(rd_mode), 128'(2'b00));
        chk("mid_rst_state_out", state_out, 128'd0);
        chk("mid_rst_block_out", block_out, 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'(1'b0));
        chk("mid_rst_done", 128'(done), 128'(1'b0));
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("mid_no_done_after_reset", 128'(ndone), 128'(0));
        chk("mid_idle_busy", 128'(busy), 128'(1'b0));
        do_start(2'b00, PT);
        wait_done(161, CT1, "post_reset_c1", bc);
        chk("post_reset_busy_cycles", 128'(bc), 128'(161));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
